// File: rtl/neopixel_strand_ctrl_param_if.sv
// Load/send handshake bundle between the pixel-update logic and the strand controller.
interface neopixel_strand_ctrl_param_if #(
    parameter int unsigned PW = 3
);
    logic          load_color;
    logic          load_all;
    logic [PW-1:0] pixel_index;
    logic [1:0]    color_index;
    logic [7:0]    color_level;
    logic          send_it;
    logic          ready_to_load;
    logic          ready_to_send;

    modport master (
        output load_color, load_all, pixel_index, color_index, color_level, send_it,
        input  ready_to_load, ready_to_send
    );

    modport slave (
        input  load_color, load_all, pixel_index, color_index, color_level, send_it,
        output ready_to_load, ready_to_send
    );
endinterface

// File: rtl/neopixel_strand_ctrl_param.sv
// Double-buffered GRB strand controller: loads fill the back buffer, send_it snapshots it
// into a shift register that is serialised onto neo_data with parameterised bit timing.
module neopixel_strand_ctrl_param #(
    parameter int unsigned NUM_PIXELS   = 5,
    parameter int unsigned T0H          = 18,
    parameter int unsigned T0L          = 40,
    parameter int unsigned T1H          = 35,
    parameter int unsigned T1L          = 30,
    parameter int unsigned LATCH_CYCLES = 2500
) (
    input  logic                               clock,
    input  logic                               reset,
    neopixel_strand_ctrl_param_if.slave        bus,
    output logic                               neo_data,
    output logic                               frame_done
);
    localparam int unsigned PW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int unsigned FRAME_BITS = 24 * NUM_PIXELS;
    localparam int unsigned BW         = $clog2(FRAME_BITS);
    localparam int unsigned MAX_H      = (T0H > T1H) ? T0H : T1H;
    localparam int unsigned MAX_L      = (T0L > T1L) ? T0L : T1L;
    localparam int unsigned MAX_HL     = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int unsigned MAX_T      = (MAX_HL > LATCH_CYCLES) ? MAX_HL : LATCH_CYCLES;
    localparam int unsigned TW         = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_H = 2'd1,
        SEND_L = 2'd2,
        LATCH  = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [NUM_PIXELS-1:0][23:0]  back_q, back_d;
    logic [FRAME_BITS-1:0]        front_q, front_d;
    logic [FRAME_BITS-1:0]        back_flat;
    logic [BW-1:0]                bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic                         neo_q, neo_d;
    logic                         done_q, done_d;
    logic                         rts_q, rts_d;
    logic                         load_ok;

    // Timer reload values are stored as length-1 so the phase ends on timer==0.
    function automatic logic [TW-1:0] high_len(input logic b);
        return b ? TW'(T1H - 1) : TW'(T0H - 1);
    endfunction

    function automatic logic [TW-1:0] low_len(input logic b);
        return b ? TW'(T1L - 1) : TW'(T0L - 1);
    endfunction

    assign load_ok = bus.load_color && (bus.color_index != 2'b11);

    // Per-pixel channel writes; out-of-range indices match no pixel and are dropped.
    for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_pix
        logic sel;
        assign sel = load_ok && (bus.load_all || (bus.pixel_index == PW'(g)));
        assign back_d[g][23:16] = (sel && bus.color_index == 2'b10) ? bus.color_level
                                                                     : back_q[g][23:16];
        assign back_d[g][15:8]  = (sel && bus.color_index == 2'b00) ? bus.color_level
                                                                     : back_q[g][15:8];
        assign back_d[g][7:0]   = (sel && bus.color_index == 2'b01) ? bus.color_level
                                                                     : back_q[g][7:0];
        assign back_flat[FRAME_BITS-1-24*g -: 24] = back_q[g];
    end

    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        neo_d     = neo_q;
        done_d    = 1'b0;
        rts_d     = rts_q;
        case (state_q)
            IDLE: begin
                if (bus.send_it) begin
                    state_d   = SEND_H;
                    front_d   = back_flat;
                    bit_cnt_d = '0;
                    timer_d   = high_len(back_flat[FRAME_BITS-1]);
                    neo_d     = 1'b1;
                    rts_d     = 1'b0;
                end
            end
            SEND_H: begin
                if (timer_q == '0) begin
                    state_d = SEND_L;
                    neo_d   = 1'b0;
                    timer_d = low_len(front_q[FRAME_BITS-1]);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            SEND_L: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                    state_d = LATCH;
                    timer_d = TW'(LATCH_CYCLES - 1);
                end else begin
                    // Current bit always sits at the MSB of the shift register.
                    state_d   = SEND_H;
                    front_d   = {front_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    timer_d   = high_len(front_q[FRAME_BITS-2]);
                    neo_d     = 1'b1;
                end
            end
            LATCH: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rts_d   = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                neo_d   = 1'b0;
                rts_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            back_q    <= '0;
            front_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            neo_q     <= 1'b0;
            done_q    <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            back_q    <= back_d;
            front_q   <= front_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            neo_q     <= neo_d;
            done_q    <= done_d;
            rts_q     <= rts_d;
        end
    end

    assign neo_data          = neo_q;
    assign frame_done        = done_q;
    assign bus.ready_to_send = rts_q;
    assign bus.ready_to_load = 1'b1;
endmodule

// File: tb/tb_neopixel_strand_ctrl_param.sv
// Bench for the strand controller: directed and random loads/frames, decoded from the
// neo_data waveform and compared against a per-channel colour model.
module tb_neopixel_strand_ctrl_param;
    localparam int unsigned NP    = 2;
    localparam int unsigned T0H   = 2;
    localparam int unsigned T0L   = 3;
    localparam int unsigned T1H   = 3;
    localparam int unsigned T1L   = 2;
    localparam int unsigned LATCH = 10;
    localparam int unsigned NBITS = 24 * NP;

    logic clk = 1'b0;
    logic rst;
    logic neo_data;
    logic frame_done;

    neopixel_strand_ctrl_param_if #(.PW(1)) bus();

    neopixel_strand_ctrl_param #(
        .NUM_PIXELS(NP), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .LATCH_CYCLES(LATCH)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus),
        .neo_data(neo_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Colour model: back buffer per channel, plus the snapshot of the frame in flight.
    logic [7:0] mr[NP], mg[NP], mb[NP];
    logic [7:0] fr[NP], fg[NP], fb[NP];
    logic [NBITS-1:0] got_bits;

    // Optional mid-frame action, fired by tick() when cyc reaches act_cyc.
    int         act_cyc = -1;
    bit         act_load, act_all, act_send;
    int         act_pix, act_ci;
    logic [7:0] act_lvl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int p = 0; p < NP; p++) begin
            mr[p] = 8'h00; mg[p] = 8'h00; mb[p] = 8'h00;
        end
    endtask

    task automatic mdl_load(input bit all, input int pix, input int ci, input logic [7:0] lvl);
        if (ci == 3) return;
        for (int p = 0; p < NP; p++) begin
            if (all || pix == p) begin
                case (ci)
                    0:       mr[p] = lvl;
                    1:       mb[p] = lvl;
                    default: mg[p] = lvl;
                endcase
            end
        end
    endtask

    task automatic drive_load(input bit all, input int pix, input int ci, input logic [7:0] lvl);
        bus.load_color  = 1'b1;
        bus.load_all    = all;
        bus.pixel_index = 1'(pix);
        bus.color_index = 2'(ci);
        bus.color_level = lvl;
        mdl_load(all, pix, ci, lvl);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.load_color = 1'b0;
        bus.load_all   = 1'b0;
        bus.send_it    = 1'b0;
        if (cyc == act_cyc) begin
            if (act_load) drive_load(act_all, act_pix, act_ci, act_lvl);
            bus.send_it = act_send;
        end
    endtask

    task automatic load(input bit all, input int pix, input int ci, input logic [7:0] lvl);
        drive_load(all, pix, ci, lvl);
        tick();
    endtask

    // Start a frame (optionally with a load on the same edge) and decode the waveform.
    task automatic run_frame(input string tag, input bit same_load, input bit all,
                             input int pix, input int ci, input logic [7:0] lvl);
        bit q[$];
        logic [NBITS-1:0] exp_bits;
        int hi, lo, exp_hi, exp_lo, exp_total, tim_bad, rts_bad, fd_bad;
        check({tag, ":rts_before"}, 64'(bus.ready_to_send), 64'd1);
        bus.send_it = 1'b1;
        for (int p = 0; p < NP; p++) begin
            fr[p] = mr[p]; fg[p] = mg[p]; fb[p] = mb[p];
        end
        if (same_load) drive_load(all, pix, ci, lvl);
        for (int p = 0; p < NP; p++) begin
            for (int b = 7; b >= 0; b--) q.push_back(fg[p][b]);
            for (int b = 7; b >= 0; b--) q.push_back(fr[p][b]);
            for (int b = 7; b >= 0; b--) q.push_back(fb[p][b]);
        end
        exp_total = LATCH;
        for (int i = 0; i < NBITS; i++) begin
            exp_bits[NBITS-1-i] = q[i];
            exp_total += q[i] ? (T1H + T1L) : (T0H + T0L);
        end
        tim_bad = 0; rts_bad = 0; fd_bad = 0;
        cyc = 0;
        tick();
        for (int i = 0; i < NBITS; i++) begin
            exp_hi = q[i] ? T1H : T0H;
            exp_lo = (q[i] ? T1L : T0L) + ((i == NBITS - 1) ? LATCH : 0);
            hi = 0;
            while (neo_data === 1'b1 && hi < 64) begin
                if (bus.ready_to_send !== 1'b0) rts_bad++;
                if (frame_done !== 1'b0) fd_bad++;
                hi++;
                tick();
            end
            lo = 0;
            while (neo_data === 1'b0 && frame_done !== 1'b1 && lo < 64) begin
                if (bus.ready_to_send !== 1'b0) rts_bad++;
                lo++;
                tick();
            end
            got_bits[NBITS-1-i] = (hi == T1H);
            if (hi != exp_hi || lo != exp_lo) tim_bad++;
        end
        check({tag, ":bits"}, 64'(got_bits), 64'(exp_bits));
        check({tag, ":bit_timing_errs"}, 64'(tim_bad), 64'd0);
        check({tag, ":frame_len"}, 64'(cyc - 1), 64'(exp_total));
        check({tag, ":frame_done"}, 64'(frame_done), 64'd1);
        check({tag, ":rts_at_done"}, 64'(bus.ready_to_send), 64'd1);
        check({tag, ":rts_busy"}, 64'(rts_bad), 64'd0);
        check({tag, ":early_done"}, 64'(fd_bad), 64'd0);
    endtask

    task automatic check_quiet(input string tag, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            tick();
            if (neo_data !== 1'b0 || frame_done !== 1'b0 || bus.ready_to_send !== 1'b1) bad++;
        end
        check({tag, ":quiet"}, 64'(bad), 64'd0);
    endtask

    initial begin
        bit sl, sa, ra;
        int sp, sc, nl;
        logic [7:0] sv;
        rst = 1'b1;
        bus.load_color = 1'b0; bus.load_all = 1'b0; bus.pixel_index = 1'b0;
        bus.color_index = 2'b00; bus.color_level = 8'h00; bus.send_it = 1'b0;
        mdl_clear();
        tick(); tick();
        check("rst:ready_to_load", 64'(bus.ready_to_load), 64'd1);
        check("rst:neo_data", 64'(neo_data), 64'd0);
        check("rst:ready_to_send", 64'(bus.ready_to_send), 64'd1);
        check("rst:frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        tick();

        load(1'b0, 1, 0, 8'hFF);
        run_frame("single", 1'b0, 1'b0, 0, 0, 8'h00);
        check("single:ready_to_load", 64'(bus.ready_to_load), 64'd1);

        load(1'b0, 0, 1, 8'h77);
        load(1'b0, 0, 2, 8'hB3);
        load(1'b0, 0, 3, 8'hD4);
        load(1'b0, 1, 3, 8'hD4);
        run_frame("invalid", 1'b0, 1'b0, 0, 0, 8'h00);
        check("invalid:pix0", 64'(got_bits[47:24]), 64'h00B3_0077);
        check("invalid:pix1", 64'(got_bits[23:0]), 64'h0000_FF00);

        load(1'b1, 0, 0, 8'h50);
        run_frame("fill", 1'b0, 1'b0, 0, 0, 8'h00);
        check("fill:bits8_15", 64'(got_bits[39:32]), 64'h50);
        check("fill:bits32_39", 64'(got_bits[15:8]), 64'h50);

        // Back-to-back: resend on the frame_done cycle with no loads in between.
        run_frame("resend", 1'b0, 1'b0, 0, 0, 8'h00);

        act_cyc = 40; act_load = 1'b1; act_all = 1'b0; act_pix = 0; act_ci = 2;
        act_lvl = 8'hFF; act_send = 1'b1;
        run_frame("during", 1'b0, 1'b0, 0, 0, 8'h00);
        act_cyc = -1;
        check_quiet("during_ignored", 4);
        run_frame("after", 1'b0, 1'b0, 0, 0, 8'h00);
        check("after:g0", 64'(got_bits[47:40]), 64'hFF);

        bus.send_it = 1'b1;
        cyc = 0;
        tick();
        while (cyc < 60) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_clear();
        check("midrst:neo_data", 64'(neo_data), 64'd0);
        check("midrst:ready_to_send", 64'(bus.ready_to_send), 64'd1);
        check("midrst:frame_done", 64'(frame_done), 64'd0);
        check_quiet("midrst", 40);
        run_frame("postrst", 1'b0, 1'b0, 0, 0, 8'h00);

        for (int it = 0; it < 8; it++) begin
            nl = $urandom_range(0, 4);
            repeat (nl) begin
                ra = ($urandom_range(0, 3) == 0);
                load(ra, $urandom_range(0, 1), $urandom_range(0, 3), 8'($urandom));
            end
            act_cyc  = $urandom_range(2, 200);
            act_load = 1'($urandom);
            act_all  = ($urandom_range(0, 3) == 0);
            act_pix  = $urandom_range(0, 1);
            act_ci   = $urandom_range(0, 3);
            act_lvl  = 8'($urandom);
            act_send = 1'($urandom);
            sl = 1'($urandom); sa = ($urandom_range(0, 3) == 0);
            sp = $urandom_range(0, 1); sc = $urandom_range(0, 3); sv = 8'($urandom);
            run_frame($sformatf("rand%0d", it), sl, sa, sp, sc, sv);
            act_cyc = -1;
            check_quiet($sformatf("rand%0d", it), 3);
        end
        run_frame("final", 1'b0, 1'b0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neopixel_strand_ctrl_param.md
# neopixel_strand_ctrl_param

Parametrised NeoPixel (WS2812-class) strand controller, the successor to the fixed 5-pixel controller. Holds a double-buffered GRB frame for `NUM_PIXELS` pixels and accepts per-channel color loads at any time, including during transmission. On `send_it` it snapshots the load buffer and serialises it onto `neo_data` with parameterised bit and latch timing. It sits between the pixel-update logic and the single strand data pin.

## Interface
- `NUM_PIXELS`, 5: pixels on the strand; must be ≥1. `PW = max(1,$clog2(NUM_PIXELS))`.
- `T0H`, 18: cycles high for a 0 bit.
- `T0L`, 40: cycles low for a 0 bit.
- `T1H`, 35: cycles high for a 1 bit.
- `T1L`, 30: cycles low for a 1 bit.
- All four `TxH`/`TxL` values must be ≥1.
- `LATCH_CYCLES`, 2500: low-time after the frame (50 µs at 50 MHz); must be ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_color` in 1: write strobe.
- `load_all` in 1: with `load_color`, write the channel of every pixel.
- `pixel_index` in PW: target pixel.
- `color_index` in 2: 00=red, 01=blue, 10=green, 11=invalid.
- `color_level` in 8: channel intensity.
- `send_it` in 1: start a frame.
- `neo_data` out 1: strand data, registered.
- `ready_to_load` out 1: loads accepted.
- `ready_to_send` out 1: controller idle, `send_it` will be accepted.
- `frame_done` out 1: one-cycle pulse at the end of the latch gap.

## Operation
- Two buffers, each NUM_PIXELS×24 bits:
  - Back buffer is written by loads.
  - Front buffer is read by the serialiser.
- Load, on an edge with `load_color=1` and `reset=0`:
  - Writes `color_level` to channel `color_index` of the back buffer at `pixel_index`, or of all pixels if `load_all=1`.
  - `color_index=11` is ignored (no write).
  - `pixel_index ≥ NUM_PIXELS` with `load_all=0` is ignored.
  - Loads are accepted in every state.
- Wire order:
  - Pixel 0 first.
  - Within each pixel: G[7:0], R[7:0], B[7:0], MSB first.
  - Frame = 24·NUM_PIXELS bits.
- FSM states:
  - IDLE: `send_it=1` → copy back to front, bit counter=0 → SEND_H.
  - SEND_H: `neo_data=1` for T0H or T1H cycles, per current bit → SEND_L.
  - SEND_L: `neo_data=0` for T0L or T1L cycles. Then → SEND_H with the next bit, or → LATCH after the last bit.
  - LATCH: `neo_data=0` for LATCH_CYCLES cycles, then `frame_done` pulses for 1 cycle → IDLE.
- `send_it` is ignored outside IDLE; there is no queueing.
- A load on the same edge as an accepted `send_it` goes to the back buffer only. It is not part of that frame; the snapshot takes the pre-edge contents.
- Back-buffer contents persist across frames. Resending without loads transmits the same frame.

## Timing
- Reset values:
  - State IDLE.
  - Both buffers 0.
  - `neo_data=0`, `frame_done=0`.
  - `ready_to_send=1`, `ready_to_load=1`.
- Reset mid-frame: the next cycle is IDLE with `neo_data=0` and buffers cleared. No latch gap or `frame_done` is produced.
- `ready_to_load` is 1 in every cycle, including during reset.
- `ready_to_send` is 1 only while in IDLE. It drops on the cycle after the accepting edge.
- Latency: `send_it` sampled at edge k → `neo_data=1` from edge k+1.
- Bit period:
  - 0 bit: T0H+T0L cycles.
  - 1 bit: T1H+T1L cycles.
  - No gap cycles between bits.
- Frame length = Σ(bit periods) + LATCH_CYCLES.
- `frame_done` is high on the last LATCH cycle's successor edge. `ready_to_send` rises on that same edge.
- The earliest back-to-back `send_it` is on the edge where `ready_to_send` is first seen high.
- A load becomes visible in the next frame accepted on a later edge.

## Test plan
Bench parameters: NUM_PIXELS=2, T0H=2, T0L=3, T1H=3, T1L=2, LATCH_CYCLES=10.

- **Reset values:** hold reset 2 cycles → `neo_data=0`, `ready_to_send=1`, `ready_to_load=1`, `frame_done=0`.
- **Single-channel frame:** load red=FF pixel 1, then `send_it`.
  - `neo_data` rises the next cycle.
  - First 32 bits are 0s: 2 high / 3 low each.
  - Then 8 ones: 3 high / 2 low each.
  - Then 8 zeros.
  - Then 10 low cycles, then a `frame_done` pulse; frame is 250 cycles.
- **Invalid/out-of-range loads:** load blue=77 pixel 0, green=B3 pixel 0, `color_index=11`/level D4, and `pixel_index=3` → front buffer pixel 0 = {G=B3,R=00,B=77}; pixel 1 unchanged.
- **Fill mode:** `load_all=1`, red=50 → both pixels R=50. Verify bits 8–15 and 32–39 = 0101_0000.
- **Load during send:** mid-frame, load green=FF pixel 0 and pulse `send_it`.
  - The current frame is unchanged.
  - The second `send_it` is ignored.
  - After `frame_done`, a new `send_it` sends G=FF.
- **Reset mid-frame:** assert reset at cycle 60 → `neo_data=0` the next cycle, `ready_to_send=1`, no `frame_done`, buffers read 0.
